// File: rtl/dma_bus_master.sv
// Single-channel bus initiator: copies halfwords or words from src to dst,
// one read then one write per unit, with the write data overlapping the next access.
module dma_bus_master #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [31:0]        cfg_src,
    input  logic [31:0]        cfg_dst,
    input  logic [COUNT_W-1:0] cfg_count,
    input  logic               cfg_word,
    input  logic [1:0]         cfg_src_ctl,
    input  logic [1:0]         cfg_dst_ctl,
    output logic               bus_req,
    input  logic               bus_gnt,
    output logic [31:0]        addr,
    output logic [31:0]        wdata,
    output logic [1:0]         size,
    output logic               write,
    input  logic [31:0]        rdata,
    input  logic               pause,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD   = 3'd2,
        S_WR   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        src_q, src_d;
    logic [31:0]        dst_q, dst_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [COUNT_W-1:0] rem_q, rem_d;
    logic               word_q, word_d;
    logic [1:0]         src_ctl_q, src_ctl_d;
    logic [1:0]         dst_ctl_q, dst_ctl_d;
    logic               lane_q, lane_d;
    logic [1:0]         size_q, size_d;
    logic               write_q, write_d;
    logic               bus_req_q, bus_req_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               stall_s;
    logic               abort_s;
    logic [15:0]        half_s;

    function automatic logic [31:0] align_addr(input logic [31:0] a, input logic word);
        if (word) begin
            align_addr = {a[31:2], 2'b00};
        end else begin
            align_addr = {a[31:1], 1'b0};
        end
    endfunction

    function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [1:0] ctl,
                                              input logic word);
        logic [31:0] step;
        step = word ? 32'd4 : 32'd2;
        case (ctl)
            2'b01:   step_addr = a - step;
            2'b10:   step_addr = a;
            default: step_addr = a + step;
        endcase
    endfunction

    // Next-state, working-register and registered-output computation.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        wdata_d   = wdata_q;
        rem_d     = rem_q;
        word_d    = word_q;
        src_ctl_d = src_ctl_q;
        dst_ctl_d = dst_ctl_q;
        lane_d    = lane_q;
        done_d    = 1'b0;
        err_d     = err_q;
        addr_d    = 32'h0000_0000;
        write_d   = 1'b0;
        size_d    = 2'b10;
        half_s    = lane_q ? rdata[31:16] : rdata[15:0];

        // Losing the grant once on the bus behaves exactly like a stall.
        if (state_q == S_IDLE) begin
            stall_s = 1'b0;
        end else if (state_q == S_REQ) begin
            stall_s = pause;
        end else begin
            stall_s = pause | ~bus_gnt;
        end
        abort_s = (state_q != S_IDLE) & ~stall_s & abort;

        if (abort_s) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
        end else if (stall_s) begin
            state_d = state_q;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        src_d     = align_addr(cfg_src, cfg_word);
                        dst_d     = align_addr(cfg_dst, cfg_word);
                        rem_d     = cfg_count;
                        word_d    = cfg_word;
                        src_ctl_d = cfg_src_ctl;
                        dst_ctl_d = cfg_dst_ctl;
                        err_d     = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_REQ: begin
                    if (bus_gnt) begin
                        state_d = S_RD;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_RD: begin
                    lane_d  = src_q[1];
                    src_d   = step_addr(src_q, src_ctl_q, word_q);
                    state_d = S_WR;
                end
                S_WR: begin
                    wdata_d = word_q ? rdata : {half_s, half_s};
                    dst_d   = step_addr(dst_q, dst_ctl_q, word_q);
                    rem_d   = rem_q - COUNT_W'(1'b1);
                    if (rem_d != '0) begin
                        state_d = S_RD;
                    end else begin
                        state_d = S_FIN;
                    end
                end
                S_FIN: begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        bus_req_d = (state_d != S_IDLE);
        busy_d    = (state_d != S_IDLE);
        case (state_d)
            S_RD: begin
                addr_d  = src_d;
                write_d = 1'b0;
                size_d  = word_d ? 2'b10 : 2'b01;
            end
            S_WR: begin
                addr_d  = dst_d;
                write_d = 1'b1;
                size_d  = word_d ? 2'b10 : 2'b01;
            end
            default: begin
                addr_d  = 32'h0000_0000;
                write_d = 1'b0;
                size_d  = 2'b10;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            src_q     <= 32'h0000_0000;
            dst_q     <= 32'h0000_0000;
            addr_q    <= 32'h0000_0000;
            wdata_q   <= 32'h0000_0000;
            rem_q     <= '0;
            word_q    <= 1'b0;
            src_ctl_q <= 2'b00;
            dst_ctl_q <= 2'b00;
            lane_q    <= 1'b0;
            size_q    <= 2'b10;
            write_q   <= 1'b0;
            bus_req_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rem_q     <= rem_d;
            word_q    <= word_d;
            src_ctl_q <= src_ctl_d;
            dst_ctl_q <= dst_ctl_d;
            lane_q    <= lane_d;
            size_q    <= size_d;
            write_q   <= write_d;
            bus_req_q <= bus_req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus_req = bus_req_q;
    assign addr    = addr_q;
    assign wdata   = wdata_q;
    assign size    = size_q;
    assign write   = write_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_dma_bus_master.sv
// Directed bench for dma_bus_master with a small behavioural memory on the bus.
module tb_dma_bus_master;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   cfg_src = 32'h0;
    logic [31:0]   cfg_dst = 32'h0;
    logic [CW-1:0] cfg_count = '0;
    logic          cfg_word = 1'b0;
    logic [1:0]    cfg_src_ctl = 2'b00;
    logic [1:0]    cfg_dst_ctl = 2'b00;
    logic          bus_req;
    logic          bus_gnt = 1'b1;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [1:0]    size;
    logic          write;
    logic [31:0]   rdata = 32'h0;
    logic          pause = 1'b0;
    logic          abort = 1'b0;
    logic          busy;
    logic          done;
    logic          err;

    dma_bus_master #(.COUNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_count(cfg_count),
        .cfg_word(cfg_word), .cfg_src_ctl(cfg_src_ctl), .cfg_dst_ctl(cfg_dst_ctl),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .addr(addr), .wdata(wdata),
        .size(size), .write(write), .rdata(rdata), .pause(pause), .abort(abort),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [logic [29:0]];
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic [1:0]  pend_size = 2'b00;
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a[31:2])) return mem[a[31:2]];
        else return 32'h0;
    endfunction

    task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        logic [31:0] w;
        w = mem_rd(a);
        if (sz == 2'b10) w = d;
        else if (a[1]) w[31:16] = d[31:16];
        else w[15:0] = d[15:0];
        mem[a[31:2]] = w;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Completes the current bus cycle in the memory model, then advances to the next cycle.
    task automatic step();
        if (!rst_n) begin
            pend = 1'b0;
        end else if (!pause && bus_gnt) begin
            if (pend) mem_wr(pend_addr, wdata, pend_size);
            pend      = write && !abort;
            pend_addr = addr;
            pend_size = size;
            if (!write) rdata = mem_rd(addr);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [CW-1:0] n,
                          input logic w, input logic [1:0] sc, input logic [1:0] dc);
        cfg_src = s; cfg_dst = d; cfg_count = n; cfg_word = w;
        cfg_src_ctl = sc; cfg_dst_ctl = dc;
        start = 1'b1;
        cyc = 0;
        step();
        start = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst addr", addr, 32'h0);
        check("rst wdata", wdata, 32'h0);
        check("rst size", {30'd0, size}, 32'd2);
        check("rst write", {31'd0, write}, 32'd0);
        check("rst bus_req", {31'd0, bus_req}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        step();

        // Word copy, inc/inc.
        for (int i = 0; i < 4; i++) mem_wr(32'h0300_0000 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1), 2'b10);
        launch(32'h0300_0000, 32'h0200_0100, 4'd4, 1'b1, 2'b00, 2'b00);
        check("wc req", {31'd0, bus_req}, 32'd1);
        check("wc busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("wc rd addr", addr, 32'h0300_0000 + 32'(4 * k));
            check("wc rd write", {31'd0, write}, 32'd0);
            if (k > 0) check("wc wdata", wdata, 32'h1111_1111 * 32'(k));
            step();
            check("wc wr addr", addr, 32'h0200_0100 + 32'(4 * k));
            check("wc wr write", {31'd0, write}, 32'd1);
        end
        step();
        check("wc fin wdata", wdata, 32'h4444_4444);
        check("wc fin addr", addr, 32'h0);
        check("wc fin done", {31'd0, done}, 32'd0);
        step();
        check("wc done", {31'd0, done}, 32'd1);
        check("wc busy end", {31'd0, busy}, 32'd0);
        check("wc err", {31'd0, err}, 32'd0);
        for (int i = 0; i < 4; i++) check("wc mem", mem_rd(32'h0200_0100 + 32'(4 * i)), 32'h1111_1111 * 32'(i + 1));
        step();

        // Fixed source, decrementing destination.
        mem_wr(32'h0300_0040, 32'hA5A5_0001, 2'b10);
        launch(32'h0300_0040, 32'h0200_0008, 4'd3, 1'b1, 2'b10, 2'b01);
        for (int k = 0; k < 3; k++) begin
            step();
            check("fd rd addr", addr, 32'h0300_0040);
            step();
            check("fd wr addr", addr, 32'h0200_0008 - 32'(4 * k));
        end
        step();
        step();
        check("fd done", {31'd0, done}, 32'd1);
        for (int i = 0; i < 3; i++) check("fd mem", mem_rd(32'h0200_0000 + 32'(4 * i)), 32'hA5A5_0001);
        step();

        // Two paused cycles during the second write.
        launch(32'h0300_0000, 32'h0200_0200, 4'd3, 1'b1, 2'b00, 2'b00);
        repeat (4) step();
        check("ps wr addr", addr, 32'h0200_0204);
        pause = 1'b1;
        step();
        check("ps hold addr", addr, 32'h0200_0204);
        check("ps hold write", {31'd0, write}, 32'd1);
        check("ps hold wdata", wdata, 32'h1111_1111);
        step();
        check("ps hold addr2", addr, 32'h0200_0204);
        check("ps hold write2", {31'd0, write}, 32'd1);
        pause = 1'b0;
        step();
        check("ps rd addr", addr, 32'h0300_0008);
        check("ps wdata", wdata, 32'h2222_2222);
        step();
        step();
        check("ps not done yet", {31'd0, done}, 32'd0);
        step();
        check("ps done", {31'd0, done}, 32'd1);
        for (int i = 0; i < 3; i++) check("ps mem", mem_rd(32'h0200_0200 + 32'(4 * i)), 32'h1111_1111 * 32'(i + 1));
        step();

        // Abort during the read of the second unit.
        for (int i = 0; i < 4; i++) mem_wr(32'h0200_0300 + 32'(4 * i), 32'h0, 2'b10);
        launch(32'h0300_0000, 32'h0200_0300, 4'd4, 1'b1, 2'b00, 2'b00);
        repeat (3) step();
        check("ab rd addr", addr, 32'h0300_0004);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab done", {31'd0, done}, 32'd1);
        check("ab err", {31'd0, err}, 32'd1);
        check("ab busy", {31'd0, busy}, 32'd0);
        check("ab write", {31'd0, write}, 32'd0);
        check("ab addr", addr, 32'h0);
        check("ab mem0", mem_rd(32'h0200_0300), 32'h1111_1111);
        check("ab mem1", mem_rd(32'h0200_0304), 32'h0);
        step();
        check("ab err sticky", {31'd0, err}, 32'd1);
        check("ab no access", {31'd0, bus_req}, 32'd0);
        launch(32'h0300_0000, 32'h0200_0310, 4'd1, 1'b1, 2'b00, 2'b00);
        check("ab err cleared", {31'd0, err}, 32'd0);
        repeat (4) step();
        check("ab rerun done", {31'd0, done}, 32'd1);
        check("ab rerun mem", mem_rd(32'h0200_0310), 32'h1111_1111);
        step();

        // Count zero means 16 units with a 4-bit count.
        for (int i = 0; i < 16; i++) mem_wr(32'h0300_1000 + 32'(4 * i), 32'h5000_0000 + 32'(i), 2'b10);
        launch(32'h0300_1000, 32'h0200_1000, 4'd0, 1'b1, 2'b00, 2'b00);
        while (cyc < 33) step();
        check("cz last wr addr", addr, 32'h0200_103C);
        check("cz last wr write", {31'd0, write}, 32'd1);
        step();
        check("cz fin busy", {31'd0, busy}, 32'd1);
        step();
        check("cz done", {31'd0, done}, 32'd1);
        check("cz mem first", mem_rd(32'h0200_1000), 32'h5000_0000);
        check("cz mem last", mem_rd(32'h0200_103C), 32'h5000_000F);
        step();

        // Asynchronous reset in the middle of a write.
        mem_wr(32'h0200_2000, 32'h0, 2'b10);
        launch(32'h0300_0000, 32'h0200_2000, 4'd4, 1'b1, 2'b00, 2'b00);
        step();
        step();
        check("rs wr write", {31'd0, write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rs write", {31'd0, write}, 32'd0);
        check("rs addr", addr, 32'h0);
        check("rs wdata", wdata, 32'h0);
        check("rs size", {30'd0, size}, 32'd2);
        check("rs busy", {31'd0, busy}, 32'd0);
        check("rs bus_req", {31'd0, bus_req}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rs no partial write", mem_rd(32'h0200_2000), 32'h0);
        launch(32'h0300_0004, 32'h0200_2000, 4'd1, 1'b1, 2'b00, 2'b00);
        repeat (4) step();
        check("rs rerun done", {31'd0, done}, 32'd1);
        check("rs rerun mem", mem_rd(32'h0200_2000), 32'h2222_2222);
        step();

        // Halfword lane extraction.
        mem_wr(32'h0300_0000, 32'hBEEF_1234, 2'b10);
        mem_wr(32'h0300_0010, 32'hCAFE_5678, 2'b10);
        launch(32'h0300_0002, 32'h0300_0012, 4'd1, 1'b0, 2'b00, 2'b00);
        step();
        check("hl rd addr", addr, 32'h0300_0002);
        check("hl rd size", {30'd0, size}, 32'd1);
        step();
        check("hl wr addr", addr, 32'h0300_0012);
        check("hl wr size", {30'd0, size}, 32'd1);
        check("hl wr write", {31'd0, write}, 32'd1);
        step();
        check("hl wdata", wdata, 32'hBEEF_BEEF);
        step();
        check("hl done", {31'd0, done}, 32'd1);
        check("hl mem", mem_rd(32'h0300_0010), 32'hBEEF_5678);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
